multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath.
// Drives the datapath selects/strobes from the current state, plus a debug
// state output and a retired-instruction counter.
// Optional feature: define MCTRL_ADDI_EN to add the addi path (IMMEX/IMMWB).
// Without it, opcode 001000 is unsupported and encodings 10/11 are unused.
// No valid/ready handshake is involved: the FSM advances on every clock, and
// opcode is consulted only while in DECODE and MEMADR.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [5:0]  ALUOP,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_RTY  = 6'b000010;
    localparam logic [5:0] ALU_ADDI = 6'b000011;

    // Everything the datapath sees, plus the two internal PC-write terms.
    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [5:0] aluop;
        logic       pcwrite;
        logic       pcwritecond;
    } ctrl_t;

    state_t      st;
    state_t      nxt;
    ctrl_t       ctrl;
    logic        retire;
    logic [31:0] retired_q;

    // Output pattern for a given state; anything not named stays 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread  = 1'b1;
                c.irwrite  = 1'b1;
                c.alusrcb  = 2'b01;
                c.aluop    = ALU_ADD;
                c.pcwrite  = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb  = 2'b11;
                c.aluop    = ALU_ADD;
            end
            S_MEMADR: begin
                c.alusrca  = 1'b1;
                c.alusrcb  = 2'b10;
                c.aluop    = ALU_ADD;
            end
            S_MEMRD: begin
                c.memread  = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca  = 1'b1;
                c.aluop    = ALU_RTY;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = ALU_SUB;
                c.pcsource    = 2'b01;
                c.pcwritecond = 1'b1;
            end
            S_JUMP: begin
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
            end
`ifdef MCTRL_ADDI_EN
            S_IMMEX: begin
                c.alusrca  = 1'b1;
                c.alusrcb  = 2'b10;
                c.aluop    = ALU_ADDI;
            end
            S_IMMWB: begin
                c.regwrite = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; opcode matters only in DECODE and MEMADR.
    always_comb begin
        nxt = S_FETCH;
        case (st)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      nxt = S_EXEC;
                    OP_LW, OP_SW:  nxt = S_MEMADR;
                    OP_BEQ:        nxt = S_BRANCH;
                    OP_J:          nxt = S_JUMP;
`ifdef MCTRL_ADDI_EN
                    OP_ADDI:       nxt = S_IMMEX;
`endif
                    default:       nxt = S_FETCH;
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = S_MEMWB;
            S_EXEC:   nxt = S_ALUWB;
`ifdef MCTRL_ADDI_EN
            S_IMMEX:  nxt = S_IMMWB;
`endif
            default:  nxt = S_FETCH;
        endcase
    end

    // An instruction retires when a completion state hands back to FETCH;
    // the DECODE bail-out for unknown opcodes and unused encodings do not count.
    always_comb begin
        retire = 1'b0;
        case (st)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: retire = 1'b1;
`ifdef MCTRL_ADDI_EN
            S_IMMWB: retire = 1'b1;
`endif
            default: retire = 1'b0;
        endcase
    end

    // State, registered decode of the state being entered, and retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_FETCH;
            ctrl      <= decode(S_FETCH);
            retired_q <= 32'd0;
        end else begin
            st   <= nxt;
            ctrl <= decode(nxt);
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Branch resolution is the one place an input reaches an output.
    assign PCEn     = ctrl.pcwrite | (ctrl.pcwritecond & zero);
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.memread;
    assign MemWrite = ctrl.memwrite;
    assign IRWrite  = ctrl.irwrite;
    assign MemtoReg = ctrl.memtoreg;
    assign RegDst   = ctrl.regdst;
    assign RegWrite = ctrl.regwrite;
    assign ALUSrcA  = ctrl.alusrca;
    assign ALUSrcB  = ctrl.alusrcb;
    assign PCSource = ctrl.pcsource;
    assign ALUOP    = ctrl.aluop;
    assign state    = st;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed bench for multicycle_control.
// Walks each instruction class through its state sequence, checks every
// control output per cycle against a table of expected values, and checks
// the retire counter, reset behaviour and counter wrap.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        PCEn;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic [5:0]  ALUOP;
    logic [3:0]  state;
    logic [31:0] retired;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] exp_retired;

    multicycle_control dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .zero     (zero),
        .PCEn     (PCEn),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .MemtoReg (MemtoReg),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCSource (PCSource),
        .ALUOP    (ALUOP),
        .state    (state),
        .retired  (retired)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //           ALUSrcA,ALUSrcB,PCSource,ALUOP} for each state.
    function automatic logic [17:0] exp_ctrl(input logic [31:0] s);
        case (s)
            0:  return 18'b0_1_0_1_0_0_0_0_01_00_000000;
            1:  return 18'b0_0_0_0_0_0_0_0_11_00_000000;
            2:  return 18'b0_0_0_0_0_0_0_1_10_00_000000;
            3:  return 18'b1_1_0_0_0_0_0_0_00_00_000000;
            4:  return 18'b0_0_0_0_1_0_1_0_00_00_000000;
            5:  return 18'b1_0_1_0_0_0_0_0_00_00_000000;
            6:  return 18'b0_0_0_0_0_0_0_1_00_00_000010;
            7:  return 18'b0_0_0_0_0_1_1_0_00_00_000000;
            8:  return 18'b0_0_0_0_0_0_0_1_00_01_000001;
            9:  return 18'b0_0_0_0_0_0_0_0_00_10_000000;
            10: return 18'b0_0_0_0_0_0_0_1_10_00_000011;
            11: return 18'b0_0_0_0_0_0_1_0_00_00_000000;
            default: return 18'b0;
        endcase
    endfunction

    function automatic logic exp_pcen(input logic [31:0] s, input logic z);
        return (s == 0) || (s == 9) || ((s == 8) && z);
    endfunction

    function automatic logic [17:0] obs_ctrl();
        return {IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUOP};
    endfunction

    task automatic check_cycle(input string name, input logic [31:0] s, input logic z);
        check({name, " state"}, {28'd0, state}, s);
        check({name, " ctrl"}, {14'd0, obs_ctrl()}, {14'd0, exp_ctrl(s)});
        check({name, " pcen"}, {31'd0, PCEn}, {31'd0, exp_pcen(s, z)});
    endtask

    // Drives one instruction from FETCH using the state sequence in exp_q.
    // Opcode carries the real value only while the FSM may sample it.
    task automatic run_instr(input string name, input logic [5:0] op, input logic z);
        logic [31:0] cur;
        zero = z;
        cur  = exp_q.pop_front();
        check_cycle(name, cur, z);
        while (exp_q.size() > 0) begin
            opcode = (cur == 1 || cur == 2) ? op : ~op;
            step();
            cur = exp_q.pop_front();
            check_cycle(name, cur, z);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_retired = 32'd0;
        reset       = 1'b1;
        opcode      = 6'b000000;
        zero        = 1'b0;

        // Reset held: FETCH values, counter cleared.
        repeat (3) step();
        check_cycle("reset_hold", 0, 1'b0);
        check("reset_hold retired", retired, 32'd0);
        reset = 1'b0;
        check_cycle("post_release", 0, 1'b0);

        exp_q = '{0, 1, 2, 3, 4, 0};
        run_instr("lw", 6'b100011, 1'b0);
        exp_retired++;
        check("lw retired", retired, exp_retired);

        exp_q = '{0, 1, 2, 5, 0};
        run_instr("sw", 6'b101011, 1'b0);
        exp_retired++;
        check("sw retired", retired, exp_retired);

        exp_q = '{0, 1, 8, 0};
        run_instr("beq_taken", 6'b000100, 1'b1);
        exp_retired++;
        check("beq_taken retired", retired, exp_retired);

        exp_q = '{0, 1, 8, 0};
        run_instr("beq_nt", 6'b000100, 1'b0);
        exp_retired++;
        check("beq_nt retired", retired, exp_retired);

        exp_q = '{0, 1, 9, 0};
        run_instr("j", 6'b000010, 1'b0);
        exp_retired++;
        check("j retired", retired, exp_retired);

        exp_q = '{0, 1, 0};
        run_instr("bad_op", 6'b111111, 1'b0);
        check("bad_op retired", retired, exp_retired);

`ifdef MCTRL_ADDI_EN
        exp_q = '{0, 1, 10, 11, 0};
        run_instr("addi", 6'b001000, 1'b0);
        exp_retired++;
`else
        exp_q = '{0, 1, 0};
        run_instr("addi", 6'b001000, 1'b0);
`endif
        check("addi retired", retired, exp_retired);

        exp_q = '{0, 1, 6, 7, 0};
        run_instr("rtype", 6'b000000, 1'b0);
        exp_retired++;
        check("rtype retired", retired, exp_retired);

        // Reset in the middle of a load.
        opcode = 6'b100011;
        zero   = 1'b0;
        repeat (3) step();
        check("mid_lw state", {28'd0, state}, 32'd3);
        reset = 1'b1;
        step();
        check_cycle("reset_memrd", 0, 1'b0);
        check("reset_memrd retired", retired, 32'd0);
        check("reset_memrd memread", {31'd0, MemRead}, 32'd1);
        check("reset_memrd irwrite", {31'd0, IRWrite}, 32'd1);
        check("reset_memrd pcen", {31'd0, PCEn}, 32'd1);
        reset = 1'b0;
        exp_retired = 32'd0;

        // Counter wrap on completion of an R-type.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        check("wrap preload", retired, 32'hFFFF_FFFF);
        exp_q = '{0, 1, 6, 7, 0};
        run_instr("rtype_wrap", 6'b000000, 1'b0);
        check("wrap retired", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
